datapath_primitives: RTL and testbench



---
 rtl/datapath_primitives.sv | 121 ++++++++++++
 tb/tb_datapath_primitives.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/datapath_primitives.sv
// Leaf primitives of the pipelined MIPS datapath (register, 2:1 mux, 32-bit ALU)
// plus a wrapper that exposes one instance of each on independent ports.

module flopr #(
  parameter int unsigned     WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // en low is the pipeline stall: q holds for as long as it stays low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

module mux2 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? d1 : d0;

endmodule

module alu (
  input  logic        [31:0] a,
  input  logic        [31:0] b,
  input  logic        [2:0]  f,
  output logic               cout,
  output logic               zero,
  output logic        [31:0] result
);

  logic [31:0] bb;
  logic [32:0] sum;
  logic        overflow;
  logic        slt;

  // f[2] turns the adder into a subtractor: a + ~b + 1.
  assign bb  = f[2] ? ~b : b;
  assign sum = {1'b0, a} + {1'b0, bb} + {32'd0, f[2]};

  // Signed overflow of a - b: operands a and bb share a sign, the sum does not.
  assign overflow = (a[31] == bb[31]) & (sum[31] != a[31]);
  assign slt      = sum[31] ^ overflow;

  always_comb begin
    result = '0;
    unique case (f[1:0])
      2'b00: result = a & bb;
      2'b01: result = a | bb;
      2'b10: result = sum[31:0];
      2'b11: result = f[2] ? {31'd0, slt} : 32'd0;
    endcase
  end

  assign cout = sum[32];
  assign zero = (result == 32'd0);

endmodule

module datapath_primitives #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s,
  output logic [WIDTH-1:0] y,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic [2:0]       f,
  output logic             cout,
  output logic             zero,
  output logic [31:0]      result
);

  flopr #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_flopr (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .d     (d),
    .q     (q)
  );

  mux2 #(.WIDTH(WIDTH)) u_mux2 (
    .d0 (d0),
    .d1 (d1),
    .s  (s),
    .y  (y)
  );

  alu u_alu (
    .a      (a),
    .b      (b),
    .f      (f),
    .cout   (cout),
    .zero   (zero),
    .result (result)
  );

endmodule

// File: tb/tb_datapath_primitives.sv
// Directed-vector bench for datapath_primitives: register reset/load/stall,
// mux selection, and ALU arithmetic, logic and signed set-less-than.

module tb_datapath_primitives;

  logic        clk;
  logic        reset;
  logic        en;
  logic [31:0] d;
  logic [31:0] q;
  logic [31:0] d0;
  logic [31:0] d1;
  logic        s;
  logic [31:0] y;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  f;
  logic        cout;
  logic        zero;
  logic [31:0] result;

  int n_cmp;
  int n_bad;

  datapath_primitives #(.WIDTH(32), .RESET_VALUE(32'h0000_0000)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .d      (d),
    .q      (q),
    .d0     (d0),
    .d1     (d1),
    .s      (s),
    .y      (y),
    .a      (a),
    .b      (b),
    .f      (f),
    .cout   (cout),
    .zero   (zero),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic alu_vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic [2:0] vf, input logic [31:0] exp_res);
    a = va;
    b = vb;
    f = vf;
    #1;
    check({tag, ".result"}, result, exp_res);
    check({tag, ".zero"}, {31'd0, zero}, {31'd0, exp_res == 32'd0});
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    en    = 1'b0;
    d     = 32'h0000_0000;
    d0    = '0;
    d1    = '0;
    s     = 1'b0;
    a     = '0;
    b     = '0;
    f     = 3'b000;

    // Register: reset value, load, stall, async clear.
    #1;
    check("flopr.reset", q, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("flopr.reset_over_edge", q, 32'h0000_0000);

    @(negedge clk);
    reset = 1'b1;
    en    = 1'b1;
    d     = 32'h0040_0004;
    #1;
    check("flopr.release_no_edge", q, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("flopr.load", q, 32'h0040_0004);

    @(negedge clk);
    en = 1'b0;
    d  = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("flopr.stall%0d", i), q, 32'h0040_0004);
    end

    #2;
    reset = 1'b0;
    #1;
    check("flopr.async_clear", q, 32'h0000_0000);

    @(negedge clk);
    reset = 1'b1;
    en    = 1'b1;
    d     = 32'h1234_5678;
    @(posedge clk);
    #1;
    check("flopr.reload", q, 32'h1234_5678);

    // Mux selection.
    d0 = 32'h1111_1111;
    d1 = 32'h0000_0008;
    s  = 1'b0;
    #1;
    check("mux2.s0", y, 32'h1111_1111);
    s = 1'b1;
    #1;
    check("mux2.s1", y, 32'h0000_0008);

    // ALU add/sub.
    alu_vec("add5_7", 32'd5, 32'd7, 3'b010, 32'd12);
    check("add5_7.cout", {31'd0, cout}, 32'd0);
    alu_vec("sub5_7", 32'd5, 32'd7, 3'b110, 32'hFFFF_FFFE);
    check("sub5_7.cout", {31'd0, cout}, 32'd0);
    alu_vec("sub7_7", 32'd7, 32'd7, 3'b110, 32'd0);
    check("sub7_7.cout", {31'd0, cout}, 32'd1);
    alu_vec("add_wrap", 32'hFFFF_FFFF, 32'd1, 3'b010, 32'd0);
    check("add_wrap.cout", {31'd0, cout}, 32'd1);

    // ALU logic.
    alu_vec("and",    32'hF0F0_00FF, 32'h0FF0_0F0F, 3'b000, 32'h00F0_000F);
    alu_vec("or",     32'hF0F0_00FF, 32'h0FF0_0F0F, 3'b001, 32'hFFF0_0FFF);
    alu_vec("andn",   32'hF0F0_00FF, 32'h0FF0_0F0F, 3'b100, 32'hF000_00F0);
    alu_vec("orn",    32'hF0F0_00FF, 32'h0FF0_0F0F, 3'b101, 32'hF0FF_F0FF);
    alu_vec("zero011", 32'hF0F0_00FF, 32'h0FF0_0F0F, 3'b011, 32'd0);

    // ALU signed set-less-than.
    alu_vec("slt_m1_1", 32'hFFFF_FFFF, 32'd1, 3'b111, 32'd1);
    alu_vec("slt_1_m1", 32'd1, 32'hFFFF_FFFF, 3'b111, 32'd0);
    alu_vec("slt_ovf",  32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 32'd1);
    alu_vec("slt_ovf_rev", 32'h7FFF_FFFF, 32'h8000_0000, 3'b111, 32'd0);
    alu_vec("slt_eq",   32'd3, 32'd3, 3'b111, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
